// File: rtl/spi_byte_ctrl_pkg.sv
// spi_byte_ctrl_pkg
//   Shared definitions for the MicroSD SPI byte controller:
//   FSM state encoding and default SD timing (clk cycles per sclk half-period).
package spi_byte_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Half-period divisors: slow keeps sclk at or below 400 kHz for card init,
  // fast is used once the card has switched to data-transfer mode.
  localparam int SD_DIV_SLOW = 125;
  localparam int SD_DIV_FAST = 2;
  localparam int SD_DIV_W    = 8;

endpackage

// File: rtl/spi_byte_ctrl_sclk_divider.sv
// spi_byte_ctrl_sclk_divider
//   Generates the SPI clock from clk while run=1. The counter runs
//   0..DIV-1 per half-period and sclk toggles at terminal count. When run=0
//   the counter and sclk are held at zero, so every transfer starts with a
//   full low half-period.
// Ports
//   clk      in  system clock
//   reset    in  synchronous active-high reset
//   run      in  1 while the controller is shifting
//   slow_sel in  1: use DIV_SLOW, 0: use DIV_FAST (held stable by the caller)
//   sclk     out registered SPI clock, low when idle
//   rise     out sclk goes high at the coming clk edge
//   fall     out sclk goes low at the coming clk edge
module spi_byte_ctrl_sclk_divider
  import spi_byte_ctrl_pkg::*;
#(
  parameter int DIV_SLOW = SD_DIV_SLOW,
  parameter int DIV_FAST = SD_DIV_FAST,
  parameter int DW       = SD_DIV_W
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic slow_sel,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [DW-1:0] LAST_SLOW = DW'(DIV_SLOW - 1);
  localparam logic [DW-1:0] LAST_FAST = DW'(DIV_FAST - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_last;
  logic          tc;

  assign div_last = slow_sel ? LAST_SLOW : LAST_FAST;
  assign tc       = run && (div_cnt == div_last);

  // Strobes announce the toggle that happens at the same edge, letting the
  // controller sample miso / advance mosi in lockstep with sclk.
  assign rise = tc && !sclk;
  assign fall = tc && sclk;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_ctrl.sv
// spi_byte_ctrl
//   Runs one N-bit SPI mode-0 transfer per start pulse on the MicroSD path.
//   tx_data is shifted out MSB-first on mosi (changed on sclk falling),
//   miso is shifted into rx_data (sampled on sclk rising).
// Ports
//   clk, reset  system clock, synchronous active-high reset
//   start       begin a transfer (ignored while busy)
//   slow        divider select, latched at start
//   cs_en       1: assert cs_n for this transfer, 0: dummy clocks with cs_n high
//   cs_release  in IDLE without start, drive cs_n high
//   tx_data     byte to send, latched at start
//   rx_data     received byte, updated in DONE only
//   busy        transfer in progress (SHIFT and DONE)
//   done        one-cycle completion pulse, rx_data valid with it
//   sclk, mosi, miso, cs_n  card pins
module spi_byte_ctrl
  import spi_byte_ctrl_pkg::*;
#(
  parameter int N        = 8,
  parameter int DIV_SLOW = SD_DIV_SLOW,
  parameter int DIV_FAST = SD_DIV_FAST,
  parameter int DW       = SD_DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         slow,
  input  logic         cs_en,
  input  logic         cs_release,
  input  logic [N-1:0] tx_data,
  output logic [N-1:0] rx_data,
  output logic         busy,
  output logic         done,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n
);

  localparam int            BW       = (N > 2) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  state_t        state, state_nxt;
  logic          busy_nxt, done_nxt, cs_n_nxt, mosi_nxt;
  logic [N-1:0]  rx_data_nxt;
  logic [N-1:0]  tx_sh, tx_sh_nxt;
  logic [N-1:0]  rx_sh, rx_sh_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic          slow_q, slow_nxt;
  logic          run, rise, fall;

  assign run = (state == ST_SHIFT);

  spi_byte_ctrl_sclk_divider #(
    .DIV_SLOW (DIV_SLOW),
    .DIV_FAST (DIV_FAST),
    .DW       (DW)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .slow_sel (slow_q),
    .sclk     (sclk),
    .rise     (rise),
    .fall     (fall)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b1;
      rx_data <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      slow_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      cs_n    <= cs_n_nxt;
      mosi    <= mosi_nxt;
      rx_data <= rx_data_nxt;
      tx_sh   <= tx_sh_nxt;
      rx_sh   <= rx_sh_nxt;
      bit_cnt <= bit_cnt_nxt;
      slow_q  <= slow_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (fall && (bit_cnt == LAST_BIT)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    busy_nxt    = (state_nxt != ST_IDLE);
    done_nxt    = (state_nxt == ST_DONE);
    cs_n_nxt    = cs_n;
    mosi_nxt    = mosi;
    rx_data_nxt = rx_data;
    tx_sh_nxt   = tx_sh;
    rx_sh_nxt   = rx_sh;
    bit_cnt_nxt = bit_cnt;
    slow_nxt    = slow_q;
    case (state)
      ST_IDLE: begin
        mosi_nxt = 1'b1;
        if (start) begin
          tx_sh_nxt   = tx_data;
          rx_sh_nxt   = '0;
          slow_nxt    = slow;
          cs_n_nxt    = ~cs_en;
          mosi_nxt    = tx_data[N-1];
          bit_cnt_nxt = '0;
        end else if (cs_release) begin
          cs_n_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise) rx_sh_nxt = {rx_sh[N-2:0], miso};
        if (fall) begin
          if (bit_cnt == LAST_BIT) begin
            // Last bit's rising sample already landed in rx_sh.
            rx_data_nxt = rx_sh;
            mosi_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            tx_sh_nxt   = {tx_sh[N-2:0], 1'b1};
            mosi_nxt    = tx_sh[N-2];
          end
        end
      end
      ST_DONE: begin
        mosi_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_byte_ctrl.sv
module tb_spi_byte_ctrl;
  localparam int N        = 8;
  localparam int DIV_SLOW = 125;
  localparam int DIV_FAST = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       slow = 1'b0;
  logic       cs_en = 1'b0;
  logic       cs_release = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, sclk, mosi, miso, cs_n;

  always #5 clk = ~clk;

  spi_byte_ctrl #(
    .N        (N),
    .DIV_SLOW (DIV_SLOW),
    .DIV_FAST (DIV_FAST),
    .DW       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .slow       (slow),
    .cs_en      (cs_en),
    .cs_release (cs_release),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .busy       (busy),
    .done       (done),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs_n       (cs_n)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_mb = 8'hFF;

  // Bus monitor and SPI slave model (edges are seen one clk after they occur)
  int         cyc = 0, fall_cnt = 0, total_rises = 0, hp_bad = 0, hp_cnt = 0;
  int         edge_idx = 0, last_edge = 0, cs_low_cnt = 0, mosi_low_cnt = 0, done_cnt = 0;
  int         exp_hp = DIV_FAST;
  logic [7:0] mosi_cap = 8'h00;
  logic       sclk_d = 1'b0;

  assign miso = (fall_cnt < N) ? cur_mb[3'(N - 1 - fall_cnt)] : 1'b1;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    sclk_d <= sclk;
    if (!cs_n) cs_low_cnt <= cs_low_cnt + 1;
    if (!mosi) mosi_low_cnt <= mosi_low_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!busy) begin
      fall_cnt <= 0;
      edge_idx <= 0;
    end else if (sclk_d != sclk) begin
      edge_idx  <= edge_idx + 1;
      last_edge <= cyc;
      if (edge_idx > 0) begin
        hp_cnt <= hp_cnt + 1;
        if (cyc - last_edge != exp_hp) hp_bad <= hp_bad + 1;
      end
      if (sclk) begin
        total_rises <= total_rises + 1;
        mosi_cap    <= {mosi_cap[6:0], mosi};
      end else begin
        fall_cnt <= fall_cnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [7:0] t, input logic [7:0] mb, input logic s, input logic ce);
    @(negedge clk);
    tx_data = t;
    slow    = s;
    cs_en   = ce;
    cur_mb  = mb;
    start   = 1'b1;
    exp_q.push_back(mb);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded), then pops the scoreboard and checks rx_data.
  task automatic wait_done(output int lat);
    logic [7:0] e;
    lat = 0;
    while (!done && lat < 2 * N * DIV_SLOW + 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles", lat);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done: rx_data 0x%0h with empty scoreboard", rx_data);
    end else begin
      e = exp_q.pop_front();
      if (rx_data !== e) begin
        errors++;
        $display("FAIL rx_data: got 0x%0h expected 0x%0h", rx_data, e);
      end
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mb;
    logic       ce;
    logic [7:0] exp_rx;
    logic       exp_cs_n;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, r0, cl0, ml0, h0, hb0, d0, n;

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 8'h3C, 1'b0};
    vecs[1] = '{8'h00, 8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'h81, 8'h7E, 1'b0, 8'h7E, 1'b1};
    vecs[4] = '{8'h5A, 8'hC3, 1'b1, 8'hC3, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sclk", 32'(sclk), 1'b0);
    chk("reset_mosi", 32'(mosi), 1'b1);
    chk("reset_cs_n", 32'(cs_n), 1'b1);
    chk("reset_busy", 32'(busy), 1'b0);
    chk("reset_done", 32'(done), 1'b0);
    chk("reset_rx", 32'(rx_data), 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Fast transfers from the vector table
    exp_hp = DIV_FAST;
    for (int i = 0; i < 5; i++) begin
      r0 = total_rises;
      h0 = hp_cnt;
      hb0 = hp_bad;
      launch(vecs[i].tx, vecs[i].mb, 1'b0, vecs[i].ce);
      cl0 = cs_low_cnt;
      chk("start_cs_n", 32'(cs_n), 32'(vecs[i].exp_cs_n));
      chk("start_busy", 32'(busy), 1'b1);
      chk("start_mosi", 32'(mosi), 32'(vecs[i].tx[7]));
      wait_done(lat);
      chk("fast_latency", lat, 2 * N * DIV_FAST);
      chk("fast_rises", total_rises - r0, N);
      chk("mosi_bits", 32'(mosi_cap), 32'(vecs[i].tx));
      chk("done_mosi", 32'(mosi), 1'b1);
      chk("done_sclk", 32'(sclk), 1'b0);
      @(posedge clk);
      #1;
      chk("after_busy", 32'(busy), 1'b0);
      chk("after_done", 32'(done), 1'b0);
      chk("after_cs_n_hold", 32'(cs_n), 32'(vecs[i].exp_cs_n));
      chk("fast_halfperiod", hp_bad - hb0, 0);
      chk("fast_edges", hp_cnt - h0, 2 * N - 1);
      if (!vecs[i].ce) chk("dummy_cs_low", cs_low_cnt - cl0, 0);
    end

    // cs_release in IDLE, then start and cs_release together
    @(negedge clk);
    cs_release = 1'b1;
    @(posedge clk);
    #1;
    chk("cs_release", 32'(cs_n), 1'b1);
    launch(8'h3C, 8'h96, 1'b0, 1'b1);
    cs_release = 1'b0;
    chk("start_beats_release", 32'(cs_n), 1'b0);
    wait_done(lat);
    @(posedge clk);
    #1;
    @(negedge clk);
    cs_release = 1'b1;
    @(posedge clk);
    #1;
    cs_release = 1'b0;
    chk("cs_release2", 32'(cs_n), 1'b1);

    // Ten slow dummy-clock transfers
    exp_hp = DIV_SLOW;
    r0 = total_rises;
    h0 = hp_cnt;
    hb0 = hp_bad;
    cl0 = cs_low_cnt;
    ml0 = mosi_low_cnt;
    for (int k = 0; k < 10; k++) begin
      launch(8'hFF, 8'(8'h11 * k), 1'b1, 1'b0);
      wait_done(lat);
      chk("slow_latency", lat, 2 * N * DIV_SLOW);
      @(posedge clk);
      #1;
    end
    chk("slow_rises", total_rises - r0, 10 * N);
    chk("slow_edges", hp_cnt - h0, 10 * (2 * N - 1));
    chk("slow_halfperiod", hp_bad - hb0, 0);
    chk("slow_cs_low", cs_low_cnt - cl0, 0);
    chk("slow_mosi_low", mosi_low_cnt - ml0, 0);

    // Start while busy ignored; start in the cycle busy falls accepted
    exp_hp = DIV_FAST;
    r0 = total_rises;
    d0 = done_cnt;
    launch(8'h96, 8'h69, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    tx_data = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("busy_start_latency", lat, 2 * N * DIV_FAST - 6);
    chk("busy_start_mosi", 32'(mosi_cap), 8'h96);
    @(posedge clk);
    #1;
    chk("gap_busy", 32'(busy), 1'b0);
    chk("gap_sclk", 32'(sclk), 1'b0);
    tx_data = 8'hC3;
    cur_mb = 8'h5A;
    start = 1'b1;
    exp_q.push_back(8'h5A);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1'b1);
    wait_done(lat);
    chk("b2b_latency", lat, 2 * N * DIV_FAST);
    @(posedge clk);
    #1;
    chk("b2b_rises", total_rises - r0, 2 * N);
    chk("b2b_dones", done_cnt - d0, 2);

    // Reset after the third rising sclk edge
    launch(8'hF0, 8'h0F, 1'b0, 1'b1);
    r0 = total_rises;
    n = 0;
    while (total_rises - r0 < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_3rd_rise", total_rises - r0, 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_sclk", 32'(sclk), 1'b0);
    chk("abort_cs_n", 32'(cs_n), 1'b1);
    chk("abort_busy", 32'(busy), 1'b0);
    chk("abort_done", 32'(done), 1'b0);
    chk("abort_rx", 32'(rx_data), 8'h00);
    chk("abort_mosi", 32'(mosi), 1'b1);
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (60) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    r0 = total_rises;
    launch(8'h3C, 8'hA5, 1'b0, 1'b1);
    wait_done(lat);
    chk("post_abort_latency", lat, 2 * N * DIV_FAST);
    chk("post_abort_mosi", 32'(mosi_cap), 8'h3C);
    chk("post_abort_rises", total_rises - r0, N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
